// File: rtl/axi_burst_dbg_master.sv
// Byte-command debug master driving AXI3 INCR bursts through a beat buffer.
// Reports slave response errors and wait-state timeouts via a status byte.
module axi_burst_dbg_master #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int BUF_DEPTH   = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_op,
  input  logic [7:0]        cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [3:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [3:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
);

  localparam int NB = DATA_W / 8;
  localparam int BW = $clog2(NB);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [3:0] LEN_MAX = 4'(BUF_DEPTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RSP  = 3'd1;
  localparam logic [2:0] S_AR   = 3'd2;
  localparam logic [2:0] S_R    = 3'd3;
  localparam logic [2:0] S_AWW  = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [NB-1:0]     strb_q, strb_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [BW-1:0]     wbyte_q, wbyte_d, rbyte_q, rbyte_d;
  logic [3:0]        beat_q, beat_d;
  logic              awdone_q, awdone_d, wdone_q, wdone_d;
  logic [31:0]       tcnt_q, tcnt_d;
  logic [7:0]        rsp_q, rsp_d;
  logic              tmo_q, tmo_d, berr_q, berr_d;
  logic              rerr_q, rerr_d, lerr_q, lerr_d;

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic              mem_we;
  logic [PW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic [ADDR_W+7:0] addr_sh;
  logic [DATA_W-1:0] rword;
  logic              aw_fire, w_fire, hs, waiting, last;

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = ~cmd_ready;
  assign rsp_valid     = (state_q == S_RSP);
  assign rsp_data      = rsp_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_arsize  = 3'(BW);
  assign m_axi_awsize  = 3'(BW);
  assign m_axi_arburst = 2'b01;
  assign m_axi_awburst = 2'b01;
  assign m_axi_arvalid = (state_q == S_AR);
  assign m_axi_rready  = (state_q == S_R);
  assign m_axi_awvalid = (state_q == S_AWW) & ~awdone_q;
  assign m_axi_wvalid  = (state_q == S_AWW) & ~wdone_q;
  assign m_axi_bready  = (state_q == S_B);
  assign m_axi_wlast   = m_axi_wvalid & (beat_q == len_q);
  assign m_axi_wdata   = mem_q[beat_q[PW-1:0]];
  assign m_axi_wstrb   = strb_q;

  assign addr_sh = {addr_q, cmd_data};
  assign rword   = mem_q[rptr_q];
  assign aw_fire = m_axi_awvalid & m_axi_awready;
  assign w_fire  = m_axi_wvalid & m_axi_wready;
  assign last    = (beat_q == len_q);
  assign waiting = (state_q == S_AR) | (state_q == S_R) |
                   (state_q == S_AWW) | (state_q == S_B);
  assign hs = ((state_q == S_AR) & m_axi_arready) |
              ((state_q == S_R) & m_axi_rvalid) |
              ((state_q == S_AWW) & (aw_fire | w_fire)) |
              ((state_q == S_B) & m_axi_bvalid);

  // Command decode, burst sequencing and wait-state timeout.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    strb_d   = strb_q;
    stage_d  = stage_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    wbyte_d  = wbyte_q;
    rbyte_d  = rbyte_q;
    beat_d   = beat_q;
    awdone_d = awdone_q;
    wdone_d  = wdone_q;
    rsp_d    = rsp_q;
    tmo_d    = tmo_q;
    berr_d   = berr_q;
    rerr_d   = rerr_q;
    lerr_d   = lerr_q;
    mem_we   = 1'b0;
    mem_wa   = wptr_q;
    mem_wd   = stage_d;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        case (cmd_op)
          8'h01: begin
            rsp_d   = 8'h7B;
            state_d = S_RSP;
          end
          8'h02: begin
            rsp_d   = {4'b0, tmo_q, berr_q, rerr_q, lerr_q};
            tmo_d   = 1'b0;
            berr_d  = 1'b0;
            rerr_d  = 1'b0;
            lerr_d  = 1'b0;
            state_d = S_RSP;
          end
          8'h20: addr_d = addr_sh[ADDR_W-1:0];
          8'h21: len_d = (cmd_data[3:0] > LEN_MAX) ? LEN_MAX : cmd_data[3:0];
          8'h22: strb_d = cmd_data[NB-1:0];
          8'h24: begin
            stage_d[{wbyte_q, 3'b000} +: 8] = cmd_data;
            wbyte_d = wbyte_q + 1'b1;
            if (&wbyte_q) begin
              mem_we = 1'b1;
              mem_wd = stage_d;
              wptr_d = wptr_q + 1'b1;
            end
          end
          8'h25: begin
            wptr_d  = '0;
            rptr_d  = '0;
            wbyte_d = '0;
            rbyte_d = '0;
          end
          8'h10: begin
            rsp_d   = rword[{rbyte_q, 3'b000} +: 8];
            rbyte_d = rbyte_q + 1'b1;
            if (&rbyte_q) rptr_d = rptr_q + 1'b1;
            state_d = S_RSP;
          end
          8'h50: begin
            beat_d  = '0;
            state_d = S_AR;
          end
          8'h51: begin
            beat_d   = '0;
            awdone_d = 1'b0;
            wdone_d  = 1'b0;
            state_d  = S_AWW;
          end
          default: ;
        endcase
      end
      S_RSP: if (rsp_ready) state_d = S_IDLE;
      S_AR: if (m_axi_arready) state_d = S_R;
      S_R: if (m_axi_rvalid) begin
        mem_we = 1'b1;
        mem_wa = beat_q[PW-1:0];
        mem_wd = m_axi_rdata;
        if (m_axi_rresp != 2'b00) rerr_d = 1'b1;
        if (m_axi_rlast != last) lerr_d = 1'b1;
        if (m_axi_rlast || last) begin
          state_d = S_IDLE;
          rptr_d  = '0;
          rbyte_d = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      S_AWW: begin
        if (aw_fire) awdone_d = 1'b1;
        if (w_fire) begin
          if (last) wdone_d = 1'b1;
          else beat_d = beat_q + 4'd1;
        end
        if (awdone_d && wdone_d) state_d = S_B;
      end
      S_B: if (m_axi_bvalid) begin
        if (m_axi_bresp != 2'b00) berr_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (waiting && !hs && tcnt_q >= 32'(TIMEOUT_CYC - 1)) begin
      state_d = S_IDLE;
      tmo_d   = 1'b1;
    end
    if (state_d != state_q || hs) tcnt_d = '0;
    else tcnt_d = tcnt_q + 32'd1;
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      strb_q   <= '1;
      stage_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      wbyte_q  <= '0;
      rbyte_q  <= '0;
      beat_q   <= '0;
      awdone_q <= 1'b0;
      wdone_q  <= 1'b0;
      tcnt_q   <= '0;
      rsp_q    <= '0;
      tmo_q    <= 1'b0;
      berr_q   <= 1'b0;
      rerr_q   <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      strb_q   <= strb_d;
      stage_q  <= stage_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wbyte_q  <= wbyte_d;
      rbyte_q  <= rbyte_d;
      beat_q   <= beat_d;
      awdone_q <= awdone_d;
      wdone_q  <= wdone_d;
      tcnt_q   <= tcnt_d;
      rsp_q    <= rsp_d;
      tmo_q    <= tmo_d;
      berr_q   <= berr_d;
      rerr_q   <= rerr_d;
      lerr_q   <= lerr_d;
    end
  end

  // Beat buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_axi_burst_dbg_master.sv
// Bench for axi_burst_dbg_master: command table plus burst sequences.
// Response bytes are checked against a queue of expected values.
module tb_axi_burst_dbg_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_op = '0;
  logic [7:0]  cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_data;
  logic        busy;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic        arready = 1'b0;
  logic        awready = 1'b0;
  logic        wready = 1'b0;
  logic        rvalid = 1'b0;
  logic        rlast = 1'b0;
  logic        bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic [1:0]  bresp = '0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi_burst_dbg_master #(
    .DATA_W(32), .ADDR_W(32), .BUF_DEPTH(16), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] op;
    logic [7:0] d;
    bit         rsp;
    logic [7:0] exp;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Response scoreboard: each accepted byte pops one expectation.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_extra: got %0h expected none", rsp_data);
      end else begin
        chk("rsp", 64'(rsp_data), 64'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [31:0] wrd(input logic [7:0] b, input int i);
    logic [7:0] x;
    x = b + 8'(4 * i);
    return {x + 8'd3, x + 8'd2, x + 8'd1, x};
  endfunction

  task automatic send(input logic [7:0] op, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) bound_fail("cmd_ready_wait");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [7:0] op, input logic [7:0] d,
                          input logic [7:0] e);
    exp_q.push_back(e);
    send(op, d);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) bound_fail("rsp_drain");
    exp_q.delete();
  endtask

  task automatic run_write(input int aw_delay, input logic [7:0] b);
    int beat = 0;
    int awn = 0;
    int bn = 0;
    int wdone_at = -1;
    int cyc = 0;
    bit early_b = 0;
    send(8'h51, 8'h00);
    while (bn == 0 && cyc < 300) begin
      awready = 1'b0;
      wready  = 1'b1;
      bvalid  = 1'b0;
      if (bready && awn == 0) early_b = 1;
      if (wvalid && beat < 4) begin
        chk($sformatf("wdata%0d", beat), 64'(wdata), 64'(wrd(b, beat)));
        chk($sformatf("wlast%0d", beat), 64'(wlast), 64'(beat == 3));
        beat++;
        if (beat == 4) wdone_at = cyc;
      end
      if (awvalid && (aw_delay < 0 ||
          (wdone_at >= 0 && cyc - wdone_at >= aw_delay))) begin
        awready = 1'b1;
        chk("awaddr", 64'(awaddr), 64'h4000_0000);
        chk("awlen", 64'(awlen), 64'd3);
        awn++;
      end
      if (bready) begin
        bvalid = 1'b1;
        bn++;
      end
      @(negedge clk);
      cyc++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    chk("w_beats", 64'(beat), 64'd4);
    chk("aw_count", 64'(awn), 64'd1);
    chk("b_count", 64'(bn), 64'd1);
    chk("bready_before_aw", 64'(early_b), 64'd0);
    chk("write_idle", 64'(busy), 64'd0);
  endtask

  task automatic run_read(input int nbeats, input int last_at,
                          input logic [7:0] b, input bit gaps);
    int beat = 0;
    int arn = 0;
    int cyc = 0;
    send(8'h50, 8'h00);
    while (beat < nbeats && cyc < 300) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      if (arvalid) begin
        arready = 1'b1;
        chk("araddr", 64'(araddr), 64'h4000_0000);
        chk("arlen", 64'(arlen), 64'd3);
        arn++;
      end else if (rready && (!gaps || cyc % 2 == 0)) begin
        rvalid = 1'b1;
        rdata  = wrd(b, beat);
        rlast  = (beat == last_at);
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    chk("ar_count", 64'(arn), 64'd1);
    chk("read_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    tv[0]  = '{8'h01, 8'h00, 1'b1, 8'h7B};
    tv[1]  = '{8'h02, 8'h00, 1'b1, 8'h00};
    tv[2]  = '{8'h77, 8'h55, 1'b0, 8'h00};
    tv[3]  = '{8'h25, 8'h00, 1'b0, 8'h00};
    tv[4]  = '{8'h24, 8'h11, 1'b0, 8'h00};
    tv[5]  = '{8'h24, 8'h22, 1'b0, 8'h00};
    tv[6]  = '{8'h24, 8'h33, 1'b0, 8'h00};
    tv[7]  = '{8'h24, 8'h44, 1'b0, 8'h00};
    tv[8]  = '{8'h10, 8'h00, 1'b1, 8'h11};
    tv[9]  = '{8'h10, 8'h00, 1'b1, 8'h22};
    tv[10] = '{8'h10, 8'h00, 1'b1, 8'h33};
    tv[11] = '{8'h10, 8'h00, 1'b1, 8'h44};
    tv[12] = '{8'h01, 8'h00, 1'b1, 8'h7B};

    repeat (2) @(negedge clk);
    chk("rst_ctrl", 64'({rsp_valid, cmd_ready, busy, wlast,
                         arvalid, awvalid, wvalid, bready}), 64'h40);
    chk("rst_addr", 64'(awaddr), 64'd0);
    chk("rst_len", 64'(awlen), 64'd0);
    chk("rst_wstrb", 64'(wstrb), 64'hF);
    chk("rst_rsp", 64'(rsp_data), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (tv[i].rsp) send_rsp(tv[i].op, tv[i].d, tv[i].exp);
      else send(tv[i].op, tv[i].d);
    end
    drain();

    rsp_ready = 1'b0;
    exp_q.push_back(8'h7B);
    send(8'h01, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_data", 64'(rsp_data), 64'h7B);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    send_rsp(8'h02, 8'h00, 8'h00);
    drain();

    send(8'h25, 8'h00);
    send(8'h20, 8'h40);
    for (int i = 0; i < 3; i++) send(8'h20, 8'h00);
    send(8'h21, 8'h03);
    send(8'h22, 8'h0F);
    for (int i = 0; i < 16; i++) send(8'h24, 8'(i));
    chk("addr_reg", 64'(awaddr), 64'h4000_0000);
    chk("size", 64'({arsize, awsize, arburst, awburst}), 64'b010010_0101);
    run_write(-1, 8'h00);

    run_read(4, 3, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) send_rsp(8'h10, 8'h00, 8'(i));
    send_rsp(8'h02, 8'h00, 8'h00);
    drain();

    run_write(10, 8'h00);
    send_rsp(8'h02, 8'h00, 8'h00);
    drain();

    begin
      int cnt = 0;
      int cyc = 0;
      send(8'h50, 8'h00);
      while (arvalid && cyc < 300) begin
        cnt++;
        @(negedge clk);
        cyc++;
      end
      chk("timeout_cycles", 64'(cnt), 64'd100);
      chk("timeout_idle", 64'(busy), 64'd0);
    end
    send_rsp(8'h02, 8'h00, 8'h08);
    send_rsp(8'h02, 8'h00, 8'h00);
    drain();

    run_read(2, 1, 8'hA0, 1'b0);
    for (int i = 0; i < 8; i++) send_rsp(8'h10, 8'h00, 8'hA0 + 8'(i));
    send_rsp(8'h02, 8'h00, 8'h01);
    drain();

    send(8'h51, 8'h00);
    @(negedge clk);
    chk("pre_reset_aw", 64'({awvalid, wvalid}), 64'b11);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_valids", 64'({awvalid, wvalid, bready, arvalid,
                             rready, rsp_valid, busy, wlast}), 64'd0);
    chk("reset_regs", 64'({awaddr, awlen, wstrb}), 64'h0_0000_0000_0F);
    @(negedge clk);
    #2 reset_n = 1'b1;
    send_rsp(8'h01, 8'h00, 8'h7B);
    send_rsp(8'h02, 8'h00, 8'h00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
